vec_to_angle: RTL
=================

VEC_TO_ANGLE -- requirements
Module: vec_to_angle

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high, with ports named Clk and Reset.
REQ-002 SHALL have parameter VEC_W, default 10, giving the signed width of the dx/dy inputs.
REQ-003 SHALL have port Clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a conversion; sampled only in IDLE.
REQ-006 SHALL have port dx, input, VEC_W bits: signed two's-complement x component; sampled with start.
REQ-007 SHALL have port dy, input, VEC_W bits: signed two's-complement y component (+y = +sin); sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high while a conversion is in progress (SCAN or DONE).
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse marking angle_o as freshly valid.
REQ-010 SHALL have port angle_o, output, 6 bits: angle index 0..44, where index i means 8*i degrees.

Function
REQ-011 SHALL be the inverse of the tank heading LUT: it maps a vector to the angle index whose unit vector best matches it.
REQ-012 SHALL define the LUT as signed 10-bit Q1.8 values, sin(i) = round(256*sin(8i deg)) and cos(i) = round(256*cos(8i deg)), for i = 0..44.
REQ-013 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-014 SHALL, in IDLE, latch dx/dy, clear idx to 0 and best_dot to the most-negative value, and go to SCAN when start=1; start=0 SHALL leave it in IDLE.
REQ-015 SHALL, in SCAN, evaluate one index per cycle: dot = dx*cos(idx) + dy*sin(idx), computed as a signed full-precision sum of VEC_W+10+1 bits with no truncation or saturation.
REQ-016 SHALL update best_dot/best_idx only when dot > best_dot (strictly greater), so ties keep the lowest index.
REQ-017 SHALL go from SCAN to DONE after evaluating idx=44; idx SHALL never exceed 44 or wrap.
REQ-018 SHALL, in DONE, drive angle_o = best_idx and done=1 for exactly one cycle, then return to IDLE.
REQ-019 SHALL assert done exactly 46 rising edges after the edge that accepted start, giving a throughput of one conversion per 47 cycles.
REQ-020 SHALL hold angle_o stable from the DONE cycle until the next DONE.
REQ-021 SHALL ignore start while busy=1; a start in the same cycle as DONE is ignored and a new start is accepted only in IDLE.
REQ-022 SHALL ignore changes on dx/dy after acceptance, because the latched copies are used.
REQ-023 SHALL return angle_o = 0 for the zero vector (dx=dy=0), as a consequence of the tie rule.
REQ-024 SHALL correctly handle dx/dy = -2^(VEC_W-1) with no overflow.

Reset
REQ-025 SHALL, on Reset=1 at a clock edge, force state=IDLE, idx=0, busy=0, done=0 and angle_o=0 regardless of state.
REQ-026 SHALL abort a SCAN when reset arrives mid-conversion; no done is produced for the aborted request.
REQ-027 SHALL give reset priority over start in the same cycle.

Structure
REQ-028 SHALL place ANGLE_COUNT=45, ANGLE_W=6, TRIG_W=10 and the FSM state enum in shared package tank_pkg.
REQ-029 SHALL instantiate sub-module trig_lut_signed: combinational, index in, signed sin/cos out, values per REQ-012; no other sub-modules.
REQ-030 SHALL keep the dot-product multiply combinational within the SCAN cycle, with no extra pipeline stage.

Verification
REQ-031 SHALL pass: dx=100, dy=0, start pulse -> done at edge +46, angle_o=0.
REQ-032 SHALL pass: dx=0, dy=100 -> angle_o=11 (88 deg; beats index 12 because 25600 > 25500).
REQ-033 SHALL pass: dx=-100, dy=0 -> angle_o=22 (indices 22 and 23 tie; the lower index wins); dx=0, dy=-100 -> angle_o=34.
REQ-034 SHALL pass: dx=dy=0 -> angle_o=0; dx=dy=-512 -> angle_o=28 (224 deg) with no overflow.
REQ-035 SHALL pass: start re-pulsed at edges +5 and +46 with a different vector -> both ignored, one done only, result from the first vector.
REQ-036 SHALL pass: Reset asserted at edge +20 of a scan -> next cycle busy=0, done=0, angle_o=0; no done follows; a new start then completes normally.

Source files
------------

// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared tank heading constants and vec_to_angle FSM state type
package tank_pkg;

   localparam int ANGLE_COUNT = 45;
   localparam int ANGLE_W     = 6;
   localparam int TRIG_W      = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } vta_state_t;

endpackage

// File: rtl/trig_lut_signed.sv
// rtl/trig_lut_signed.sv - heading LUT: Q1.8 sin/cos of 8*idx degrees, idx 0..44
module trig_lut_signed
   import tank_pkg::*;
(
   input  logic [ANGLE_W-1:0]        idx,
   output logic signed [TRIG_W-1:0]  sin_o,
   output logic signed [TRIG_W-1:0]  cos_o
);

   always_comb begin
      sin_o = 10'sd0;
      cos_o = 10'sd0;
      case (idx)
         6'd0:  begin sin_o =  10'sd0;   cos_o =  10'sd256; end
         6'd1:  begin sin_o =  10'sd36;  cos_o =  10'sd254; end
         6'd2:  begin sin_o =  10'sd71;  cos_o =  10'sd246; end
         6'd3:  begin sin_o =  10'sd104; cos_o =  10'sd234; end
         6'd4:  begin sin_o =  10'sd136; cos_o =  10'sd217; end
         6'd5:  begin sin_o =  10'sd165; cos_o =  10'sd196; end
         6'd6:  begin sin_o =  10'sd190; cos_o =  10'sd171; end
         6'd7:  begin sin_o =  10'sd212; cos_o =  10'sd143; end
         6'd8:  begin sin_o =  10'sd230; cos_o =  10'sd112; end
         6'd9:  begin sin_o =  10'sd243; cos_o =  10'sd79;  end
         6'd10: begin sin_o =  10'sd252; cos_o =  10'sd44;  end
         6'd11: begin sin_o =  10'sd256; cos_o =  10'sd9;   end
         6'd12: begin sin_o =  10'sd255; cos_o = -10'sd27;  end
         6'd13: begin sin_o =  10'sd248; cos_o = -10'sd62;  end
         6'd14: begin sin_o =  10'sd237; cos_o = -10'sd96;  end
         6'd15: begin sin_o =  10'sd222; cos_o = -10'sd128; end
         6'd16: begin sin_o =  10'sd202; cos_o = -10'sd158; end
         6'd17: begin sin_o =  10'sd178; cos_o = -10'sd184; end
         6'd18: begin sin_o =  10'sd150; cos_o = -10'sd207; end
         6'd19: begin sin_o =  10'sd120; cos_o = -10'sd226; end
         6'd20: begin sin_o =  10'sd88;  cos_o = -10'sd241; end
         6'd21: begin sin_o =  10'sd53;  cos_o = -10'sd250; end
         6'd22: begin sin_o =  10'sd18;  cos_o = -10'sd255; end
         6'd23: begin sin_o = -10'sd18;  cos_o = -10'sd255; end
         6'd24: begin sin_o = -10'sd53;  cos_o = -10'sd250; end
         6'd25: begin sin_o = -10'sd88;  cos_o = -10'sd241; end
         6'd26: begin sin_o = -10'sd120; cos_o = -10'sd226; end
         6'd27: begin sin_o = -10'sd150; cos_o = -10'sd207; end
         6'd28: begin sin_o = -10'sd178; cos_o = -10'sd184; end
         6'd29: begin sin_o = -10'sd202; cos_o = -10'sd158; end
         6'd30: begin sin_o = -10'sd222; cos_o = -10'sd128; end
         6'd31: begin sin_o = -10'sd237; cos_o = -10'sd96;  end
         6'd32: begin sin_o = -10'sd248; cos_o = -10'sd62;  end
         6'd33: begin sin_o = -10'sd255; cos_o = -10'sd27;  end
         6'd34: begin sin_o = -10'sd256; cos_o =  10'sd9;   end
         6'd35: begin sin_o = -10'sd252; cos_o =  10'sd44;  end
         6'd36: begin sin_o = -10'sd243; cos_o =  10'sd79;  end
         6'd37: begin sin_o = -10'sd230; cos_o =  10'sd112; end
         6'd38: begin sin_o = -10'sd212; cos_o =  10'sd143; end
         6'd39: begin sin_o = -10'sd190; cos_o =  10'sd171; end
         6'd40: begin sin_o = -10'sd165; cos_o =  10'sd196; end
         6'd41: begin sin_o = -10'sd136; cos_o =  10'sd217; end
         6'd42: begin sin_o = -10'sd104; cos_o =  10'sd234; end
         6'd43: begin sin_o = -10'sd71;  cos_o =  10'sd246; end
         6'd44: begin sin_o = -10'sd36;  cos_o =  10'sd254; end
         default: begin sin_o = 10'sd0; cos_o = 10'sd0; end
      endcase
   end

endmodule

// File: rtl/vec_to_angle.sv
// rtl/vec_to_angle.sv - vector to heading index by serial max-dot-product scan over the LUT
module vec_to_angle
   import tank_pkg::*;
#(
   parameter int VEC_W = 10
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               start,
   input  logic [VEC_W-1:0]   dx,
   input  logic [VEC_W-1:0]   dy,
   output logic               busy,
   output logic               done,
   output logic [ANGLE_W-1:0] angle_o
);

   localparam int DOT_W = VEC_W + TRIG_W + 1;
   localparam logic signed [DOT_W-1:0] DOT_MIN = {1'b1, {(DOT_W-1){1'b0}}};
   localparam logic [ANGLE_W-1:0] LAST_IDX = ANGLE_W'(ANGLE_COUNT - 1);

   vta_state_t                state_q, state_d;
   logic [ANGLE_W-1:0]        idx_q, idx_d;
   logic signed [VEC_W-1:0]   dx_q, dx_d;
   logic signed [VEC_W-1:0]   dy_q, dy_d;
   logic signed [DOT_W-1:0]   best_dot_q, best_dot_d;
   logic [ANGLE_W-1:0]        best_idx_q, best_idx_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic [ANGLE_W-1:0]        angle_q, angle_d;

   logic signed [TRIG_W-1:0]  sin_v, cos_v;
   logic signed [DOT_W-1:0]   dx_ext, dy_ext, sin_ext, cos_ext, dot;

   trig_lut_signed u_lut (
      .idx   (idx_q),
      .sin_o (sin_v),
      .cos_o (cos_v)
   );

   // Everything is widened to DOT_W before multiplying, so -2^(VEC_W-1) * 256 is exact.
   always_comb begin
      dx_ext  = $signed({{(TRIG_W+1){dx_q[VEC_W-1]}}, dx_q});
      dy_ext  = $signed({{(TRIG_W+1){dy_q[VEC_W-1]}}, dy_q});
      cos_ext = $signed({{(VEC_W+1){cos_v[TRIG_W-1]}}, cos_v});
      sin_ext = $signed({{(VEC_W+1){sin_v[TRIG_W-1]}}, sin_v});
      dot     = dx_ext * cos_ext + dy_ext * sin_ext;
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      best_dot_d = best_dot_q;
      best_idx_d = best_idx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      angle_d    = angle_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               dx_d       = $signed(dx);
               dy_d       = $signed(dy);
               idx_d      = '0;
               best_dot_d = DOT_MIN;
               best_idx_d = '0;
               busy_d     = 1'b1;
               state_d    = ST_SCAN;
            end
         end
         ST_SCAN: begin
            // Strict compare: on a tie the earlier (lower) index survives.
            if (dot > best_dot_q) begin
               best_dot_d = dot;
               best_idx_d = idx_q;
            end
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            angle_d = best_idx_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         dx_q       <= '0;
         dy_q       <= '0;
         best_dot_q <= DOT_MIN;
         best_idx_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         angle_q    <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         best_dot_q <= best_dot_d;
         best_idx_q <= best_idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         angle_q    <= angle_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign angle_o = angle_q;

endmodule
